// File: rtl/mem_stage_if.sv
// mem_stage_if: word-wide data RAM request/acknowledge bus.
//   master (memory stage): drives ram_req, ram_we, ram_addr and ram_wdata;
//                          samples ram_ack and ram_rdata.
//   slave  (RAM responder): mirror image of the master.
// The responder pulses ram_ack for one cycle. ram_rdata is valid only while
// ram_ack is high.
interface mem_stage_if #(
  parameter int unsigned RAM_ADDR_WIDTH = 16
);
  logic                      ram_req;
  logic                      ram_we;
  logic [RAM_ADDR_WIDTH-1:0] ram_addr;
  logic [31:0]               ram_wdata;
  logic                      ram_ack;
  logic [31:0]               ram_rdata;

  modport master (
    output ram_req, ram_we, ram_addr, ram_wdata,
    input  ram_ack, ram_rdata
  );

  modport slave (
    input  ram_req, ram_we, ram_addr, ram_wdata,
    output ram_ack, ram_rdata
  );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the pipeline.
// It consumes the EX/MEM register and performs word loads and stores through
// the ram bus. It stalls the upstream stages while an access is outstanding,
// resolves next-PC redirects and drives the registered MEM/WB outputs.
//   clk, reset_n          : clock; asynchronous active-low reset
//   in_*                  : EX/MEM register fields (in_pc_data is debug only)
//   stall                 : combinational hold request for EX/MEM and earlier stages
//   ram (master)          : req/ack data RAM bus; word address = in_alu_rd_result[RAM_ADDR_WIDTH+1:2]
//   wb_*                  : registered MEM/WB entry
//   pc_redirect(_target)  : one-cycle fetch redirect pulse and its held target
module mem_stage #(
  parameter int unsigned RAM_ADDR_WIDTH = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  input  logic [31:0] in_pc_data,
  input  logic [4:0]  in_rd_address,
  input  logic [31:0] in_alu_rd_result,
  input  logic        in_alu_rd_result_is_zero,
  input  logic [31:0] in_alu_pc_result,
  input  logic [1:0]  in_next_pc_src,
  input  logic        in_reg_write_data_src,
  input  logic        in_reg_wren,
  input  logic        in_ram_wren,
  input  logic [31:0] in_ram_write_data,
  output logic        stall,
  mem_stage_if.master ram,
  output logic        wb_valid,
  output logic [4:0]  wb_rd_address,
  output logic [31:0] wb_data,
  output logic        wb_reg_wren,
  output logic        pc_redirect,
  output logic [31:0] pc_redirect_target
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t state, state_nx;

  // Instruction fields held for the duration of a memory access
  logic [4:0]  l_rd;
  logic        l_reg_wren;
  logic [1:0]  l_src;
  logic        l_zero;
  logic [31:0] l_pc_tgt;
  logic [31:0] l_alu;
  logic        l_load;

  logic mem_op;
  logic taken_in;
  logic taken_lat;

  // in_pc_data exists for debug visibility only
  logic unused_pc;
  assign unused_pc = ^in_pc_data;

  function automatic logic redirect_taken(input logic [1:0] src, input logic zero);
    return ((src == 2'd1) && zero) || ((src == 2'd2) && !zero) || (src == 2'd3);
  endfunction

  assign mem_op    = in_valid & (in_ram_wren | (in_reg_wren & in_reg_write_data_src));
  assign taken_in  = redirect_taken(in_next_pc_src, in_alu_rd_result_is_zero);
  assign taken_lat = redirect_taken(l_src, l_zero);

  always_comb begin
    state_nx = state;
    stall    = 1'b0;
    case (state)
      IDLE: begin
        if (mem_op) begin
          stall    = 1'b1;
          state_nx = ACCESS;
        end
      end
      ACCESS: begin
        // The ack cycle does not stall, so EX/MEM advances on the retire edge
        if (ram.ram_ack) state_nx = IDLE;
        else             stall    = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ram.ram_req        <= 1'b0;
      ram.ram_we         <= 1'b0;
      ram.ram_addr       <= '0;
      ram.ram_wdata      <= '0;
      wb_valid           <= 1'b0;
      wb_rd_address      <= '0;
      wb_data            <= '0;
      wb_reg_wren        <= 1'b0;
      pc_redirect        <= 1'b0;
      pc_redirect_target <= '0;
      l_rd               <= '0;
      l_reg_wren         <= 1'b0;
      l_src              <= '0;
      l_zero             <= 1'b0;
      l_pc_tgt           <= '0;
      l_alu              <= '0;
      l_load             <= 1'b0;
    end else begin
      // Pulsed outputs default low; a retiring instruction overrides them below
      wb_valid    <= 1'b0;
      wb_reg_wren <= 1'b0;
      pc_redirect <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_op) begin
            ram.ram_req   <= 1'b1;
            ram.ram_we    <= in_ram_wren;
            ram.ram_addr  <= in_alu_rd_result[RAM_ADDR_WIDTH+1:2];
            ram.ram_wdata <= in_ram_write_data;
            l_rd          <= in_rd_address;
            l_reg_wren    <= in_reg_wren;
            l_src         <= in_next_pc_src;
            l_zero        <= in_alu_rd_result_is_zero;
            l_pc_tgt      <= in_alu_pc_result;
            l_alu         <= in_alu_rd_result;
            l_load        <= ~in_ram_wren;
          end else if (in_valid) begin
            wb_valid      <= 1'b1;
            wb_rd_address <= in_rd_address;
            wb_data       <= in_alu_rd_result;
            wb_reg_wren   <= in_reg_wren & (in_rd_address != 5'd0);
            pc_redirect   <= taken_in;
            if (taken_in) pc_redirect_target <= in_alu_pc_result;
          end
        end
        ACCESS: begin
          if (ram.ram_ack) begin
            ram.ram_req   <= 1'b0;
            wb_valid      <= 1'b1;
            wb_rd_address <= l_rd;
            wb_data       <= l_load ? ram.ram_rdata : l_alu;
            wb_reg_wren   <= l_reg_wren & (l_rd != 5'd0);
            pc_redirect   <= taken_lat;
            if (taken_lat) pc_redirect_target <= l_pc_tgt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
